heartbeat_monitor: RTL and testbench

// - Receive side of the heartbeat pad link: samples a heartbeat square wave arriving on a pad input.
// - Measures the rising-edge-to-rising-edge period and decides whether the link is locked or lost.
// - Sits beside the heartbeat generator in a cell macro, driven from the pad Y input; also drives pad controls for input mode.

---
 rtl/heartbeat_mon_pkg.sv | 26 ++
 rtl/hb_pad_sync.sv | 37 +++
 rtl/heartbeat_monitor.sv | 187 ++++++++++++++++++
 tb/tb_heartbeat_monitor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/heartbeat_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_mon_pkg
// Description : Shared state encoding and default timing constants for the
//               heartbeat pad-link receive monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package heartbeat_mon_pkg;

    // Link state as seen by the receiver
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } hb_state_t;

    // Default measurement and lock settings
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_MIN_PERIOD = 8;
    localparam int DEF_MAX_PERIOD = 12;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_ERR_W      = 8;

endpackage
`default_nettype wire

// File: rtl/hb_pad_sync.sv
`default_nettype none
// ============================================================================
// Module      : hb_pad_sync
// Description : Two-flop synchroniser for the asynchronous pad input plus a
//               single-cycle rising-edge detector on the synchronised level.
// Revision    : 1.0 - initial release
// ============================================================================
module hb_pad_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Metastability filter and one-cycle history of the synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= d;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign q    = r_sync;
    assign rise = r_sync & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module      : heartbeat_monitor
// Description : Receive side of the heartbeat pad link. Measures the
//               rise-to-rise period of the incoming square wave, tracks
//               lock/loss of the link and counts lock losses.
// Revision    : 1.0 - initial release
// ============================================================================
module heartbeat_monitor
    import heartbeat_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int ERR_W      = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_y,
    input  logic             err_clr,
    output logic             sig_oe,
    output logic             sig_ie,
    output logic             sig_pd,
    output logic             sig_pu,
    output logic             locked_o,
    output logic             lost_o,
    output logic             period_vld_o,
    output logic [CNT_W-1:0] period_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int               c_gc_w      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_min_per   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] c_max_per   = CNT_W'(MAX_PERIOD);
    localparam logic [c_gc_w-1:0] c_lock_cnt = c_gc_w'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] c_err_max   = {ERR_W{1'b1}};

    hb_state_t          r_state;
    hb_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_period;
    logic               r_period_vld;
    logic [ERR_W-1:0]   r_err;
    logic [c_gc_w-1:0]  r_gcnt;
    logic [c_gc_w-1:0]  w_gcnt_nxt;
    logic [c_gc_w-1:0]  w_gcnt_inc;
    logic               r_locked;
    logic               r_lost;
    logic               w_level;
    logic               w_rise_raw;
    logic               w_rise;
    logic [CNT_W-1:0]   w_meas;
    logic               w_good;
    logic               w_timeout;
    logic               w_err_inc;

    // The pad is a pure input with a weak pull-down so an undriven line idles low
    assign sig_oe = 1'b0;
    assign sig_ie = 1'b1;
    assign sig_pd = 1'b1;
    assign sig_pu = 1'b0;

    hb_pad_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_y),
        .q    (w_level),
        .rise (w_rise_raw)
    );

    // A detected rise always coincides with a high synchronised level
    assign w_rise = w_rise_raw & w_level;

    // Period of the edge just seen: one more than the cycles counted since the last edge
    assign w_meas    = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_good    = (w_meas >= c_min_per) && (w_meas <= c_max_per);
    // Fires on exactly one cycle per missing edge because the counter moves past the threshold
    assign w_timeout = (r_cnt == c_max_per) && !w_rise;
    assign w_gcnt_inc = r_gcnt + c_gc_w'(1);

    // Cycle counter since the last detected rise, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= '0;
        end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Publish the measured period on every rise once acquisition has started
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period     <= '0;
            r_period_vld <= 1'b0;
        end else begin
            r_period_vld <= 1'b0;
            if (w_rise && (r_state != IDLE)) begin
                r_period     <= w_meas;
                r_period_vld <= 1'b1;
            end
        end
    end

    // Link state transitions and good-period run length
    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_err_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ACQ;
                    w_gcnt_nxt  = '0;
                end
            end
            ACQ: begin
                if (w_rise) begin
                    if (w_good) begin
                        w_gcnt_nxt = w_gcnt_inc;
                        if (w_gcnt_inc == c_lock_cnt) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_gcnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = LOST;
                end
            end
            LOCKED: begin
                if ((w_rise && !w_good) || w_timeout) begin
                    w_state_nxt = LOST;
                    w_err_inc   = 1'b1;
                end
            end
            LOST: begin
                // The period ending at this rise spans the outage, so it is not counted
                if (w_rise) begin
                    w_state_nxt = ACQ;
                    w_gcnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gcnt_nxt  = '0;
            end
        endcase
    end

    // State register with registered status decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gcnt   <= '0;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_gcnt   <= w_gcnt_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_lost   <= (w_state_nxt == LOST);
        end
    end

    // Lock-loss counter; a clear request takes priority over a same-cycle loss
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else if (err_clr) begin
            r_err <= '0;
        end else if (w_err_inc && (r_err != c_err_max)) begin
            r_err <= r_err + ERR_W'(1);
        end
    end

    assign locked_o     = r_locked;
    assign lost_o       = r_lost;
    assign period_vld_o = r_period_vld;
    assign period_o     = r_period;
    assign err_cnt_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_heartbeat_monitor
// Description : Directed self-checking bench for heartbeat_monitor. A second
//               instance with a 2-bit error counter shares the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heartbeat_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_y;
    logic        err_clr;

    logic        sig_oe, sig_ie, sig_pd, sig_pu;
    logic        locked, lost, vld;
    logic [15:0] period;
    logic [7:0]  err;

    logic        sig_oe2, sig_ie2, sig_pd2, sig_pu2;
    logic        locked2, lost2, vld2;
    logic [15:0] period2;
    logic [1:0]  err2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    heartbeat_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .sig_y        (sig_y),
        .err_clr      (err_clr),
        .sig_oe       (sig_oe),
        .sig_ie       (sig_ie),
        .sig_pd       (sig_pd),
        .sig_pu       (sig_pu),
        .locked_o     (locked),
        .lost_o       (lost),
        .period_vld_o (vld),
        .period_o     (period),
        .err_cnt_o    (err)
    );

    heartbeat_monitor #(.ERR_W(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .sig_y        (sig_y),
        .err_clr      (err_clr),
        .sig_oe       (sig_oe2),
        .sig_ie       (sig_ie2),
        .sig_pd       (sig_pd2),
        .sig_pu       (sig_pu2),
        .locked_o     (locked2),
        .lost_o       (lost2),
        .period_vld_o (vld2),
        .period_o     (period2),
        .err_cnt_o    (err2)
    );

    // Raise sig_y and wait until the rise has been acted on (3 edges later)
    task automatic hb_head();
        sig_y = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Complete a period of p cycles, 'used' cycles having elapsed since the rise
    task automatic hb_tail(input int p, input int used);
        if (p / 2 > used) repeat (p / 2 - used) @(negedge clk);
        sig_y = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic hb(input int p);
        hb_head();
        hb_tail(p, 3);
    endtask

    task automatic test_reset();
        rst = 1'b1; sig_y = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({locked, lost, vld} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b expected 000", {locked, lost, vld}); end
        total++; if (period !== 16'd0) begin bad++; $display("FAIL reset_period: got %0d expected 0", period); end
        total++; if (err !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d expected 0", err); end
        total++; if ({sig_oe, sig_ie, sig_pd, sig_pu} !== 4'b0110) begin bad++; $display("FAIL pad_ctrl: got %b expected 0110", {sig_oe, sig_ie, sig_pd, sig_pu}); end
        total++; if ({locked2, lost2, vld2, period2, err2} !== 21'd0) begin bad++; $display("FAIL reset_dut2: got %h expected 0", {locked2, lost2, vld2, period2, err2}); end
        total++; if ({sig_oe2, sig_ie2, sig_pd2, sig_pu2} !== 4'b0110) begin bad++; $display("FAIL pad_ctrl2: got %b expected 0110", {sig_oe2, sig_ie2, sig_pd2, sig_pu2}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lock();
        hb_head();
        total++; if ({vld, locked, lost} !== 3'b000) begin bad++; $display("FAIL idle_first_rise: got %b expected 000", {vld, locked, lost}); end
        hb_tail(10, 3);
        for (int k = 2; k <= 4; k++) begin
            hb_head();
            total++; if ({vld, locked} !== 2'b10) begin bad++; $display("FAIL acq_rise%0d: vld,locked=%b expected 10", k, {vld, locked}); end
            total++; if (period !== 16'd10) begin bad++; $display("FAIL acq_period%0d: got %0d expected 10", k, period); end
            hb_tail(10, 3);
        end
        hb_head();
        total++; if ({locked, lost} !== 2'b10) begin bad++; $display("FAIL lock_5th: locked,lost=%b expected 10", {locked, lost}); end
        total++; if (period !== 16'd10) begin bad++; $display("FAIL lock_period: got %0d expected 10", period); end
        @(negedge clk);
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL vld_pulse_width: got %b expected 0", vld); end
    endtask

    task automatic test_timeout();
        sig_y = 1'b0;
        repeat (11) @(negedge clk);
        total++; if ({locked, lost} !== 2'b10) begin bad++; $display("FAIL pre_timeout: locked,lost=%b expected 10", {locked, lost}); end
        @(negedge clk);
        total++; if ({locked, lost} !== 2'b01) begin bad++; $display("FAIL timeout_state: locked,lost=%b expected 01", {locked, lost}); end
        total++; if (err !== 8'd1) begin bad++; $display("FAIL timeout_err: got %0d expected 1", err); end
        repeat (40) @(negedge clk);
        total++; if ({lost, err} !== {1'b1, 8'd1}) begin bad++; $display("FAIL held_low: lost=%b err=%0d expected lost=1 err=1", lost, err); end
    endtask

    task automatic test_bad_period();
        hb_head();
        total++; if ({locked, lost} !== 2'b00) begin bad++; $display("FAIL lost_to_acq: locked,lost=%b expected 00", {locked, lost}); end
        hb_tail(10, 3);
        for (int k = 0; k < 3; k++) begin
            hb_head();
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early%0d: got %b expected 0", k, locked); end
            hb_tail(10, 3);
        end
        hb_head();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock1: got %b expected 1", locked); end
        hb_tail(7, 3);
        hb_head();
        total++; if ({locked, lost} !== 2'b01) begin bad++; $display("FAIL short_period_state: locked,lost=%b expected 01", {locked, lost}); end
        total++; if (period !== 16'd7) begin bad++; $display("FAIL short_period_val: got %0d expected 7", period); end
        total++; if (err !== 8'd2) begin bad++; $display("FAIL short_period_err: got %0d expected 2", err); end
        hb_tail(10, 3);
        hb_head();
        total++; if ({locked, lost} !== 2'b00) begin bad++; $display("FAIL discard_rise: locked,lost=%b expected 00", {locked, lost}); end
        total++; if (period !== 16'd10) begin bad++; $display("FAIL discard_period: got %0d expected 10", period); end
        hb_tail(10, 3);
        for (int k = 0; k < 3; k++) begin
            hb_head();
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock2_early%0d: got %b expected 0", k, locked); end
            hb_tail(10, 3);
        end
        hb_head();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock2: got %b expected 1", locked); end
        hb_tail(10, 3);
    endtask

    task automatic test_reset_mid();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL pre_reset_locked: got %b expected 1", locked); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({locked, lost, vld, period, err} !== 27'd0) begin bad++; $display("FAIL mid_reset: got %h expected 0", {locked, lost, vld, period, err}); end
        rst = 1'b0;
    endtask

    task automatic test_acq_reject();
        hb_head();
        total++; if ({vld, locked, lost} !== 3'b000) begin bad++; $display("FAIL post_reset_rise: got %b expected 000", {vld, locked, lost}); end
        hb_tail(10, 3);
        hb(10);
        hb_head();
        hb_tail(13, 3);
        hb_head();
        total++; if (period !== 16'd13) begin bad++; $display("FAIL acq_long_period: got %0d expected 13", period); end
        total++; if ({locked, lost} !== 2'b00) begin bad++; $display("FAIL acq_long_state: locked,lost=%b expected 00", {locked, lost}); end
        hb_tail(10, 3);
        for (int k = 0; k < 3; k++) begin
            hb_head();
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL acq_after_bad%0d: got %b expected 0", k, locked); end
            hb_tail(10, 3);
        end
        hb_head();
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL acq_final_lock: got %b expected 1", locked); end
    endtask

    task automatic test_err_clr();
        sig_y = 1'b0;
        repeat (11) @(negedge clk);
        @(negedge clk);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_pre_locked: got %b expected 1", locked); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (lost !== 1'b1) begin bad++; $display("FAIL clr_lost: got %b expected 1", lost); end
        total++; if ({err, err2} !== 10'd0) begin bad++; $display("FAIL clr_priority: err=%0d err2=%0d expected 0 0", err, err2); end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 5; i++) begin
            repeat (4) hb(10);
            hb_head();
            total++; if (locked !== 1'b1) begin bad++; $display("FAIL sat_lock%0d: got %b expected 1", i, locked); end
            hb_tail(7, 3);
            hb_head();
            total++; if ({lost, lost2} !== 2'b11) begin bad++; $display("FAIL sat_lost%0d: got %b expected 11", i, {lost, lost2}); end
            total++; if (err !== 8'(i)) begin bad++; $display("FAIL sat_err%0d: got %0d expected %0d", i, err, i); end
            total++; if (err2 !== 2'((i > 3) ? 3 : i)) begin bad++; $display("FAIL sat_err2_%0d: got %0d expected %0d", i, err2, (i > 3) ? 3 : i); end
            hb_tail(10, 3);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_timeout();
        test_bad_period();
        test_reset_mid();
        test_acq_reject();
        test_err_clr();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
